// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad front end for the calculator.
// Scans columns, synchronises and debounces rows, and emits exactly one
// registered single-cycle event per physical key press.
module keypad_decoder #(
  parameter int SCAN_DIV        = 1000,  // cycles each column is driven low (>=2)
  parameter int DEBOUNCE_CYCLES = 50000  // stable cycles to accept press/release (>=1)
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit,
  output logic       validHigh,
  output logic       operand,
  output logic       opSel,
  output logic       negative,
  output logic       equals,
  output logic       memRecall,
  output logic       clear
);

  // Dwell counter must also hold the settle threshold of 2.
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SETTLE     = SW'(2);
  localparam logic [DW-1:0] CNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      col_reg, col_next;
  logic [SW-1:0]   dwell_reg, dwell_next;
  logic [DW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      pat_reg, pat_next;
  logic [1:0]      row_reg, row_next;

  logic [3:0]      rows_meta_reg;
  logic [3:0]      rs_reg;
  logic            one_low;
  logic [1:0]      low_idx;
  logic [3:0]      code;

  // Map a (row, column) position to its key code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'd1;   4'h1: k = 4'd2;   4'h2: k = 4'd3;   4'h3: k = 4'd11;
      4'h4: k = 4'd4;   4'h5: k = 4'd5;   4'h6: k = 4'd6;   4'h7: k = 4'd12;
      4'h8: k = 4'd7;   4'h9: k = 4'd8;   4'hA: k = 4'd9;   4'hB: k = 4'd14;
      4'hC: k = 4'd10;  4'hD: k = 4'd0;   4'hE: k = 4'd13;  default: k = 4'd15;
    endcase
    return k;
  endfunction

  // Active-low column drive: exactly the selected column is low.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cols
      assign cols[gi] = (col_reg != 2'(gi));
    end
  endgenerate

  assign code = key_code(row_reg, col_reg);

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge Clock) begin
    if (reset) begin
      rows_meta_reg <= 4'b1111;
      rs_reg        <= 4'b1111;
    end else begin
      rows_meta_reg <= rows;
      rs_reg        <= rows_meta_reg;
    end
  end

  // Detect exactly one low row and report its index; multi-key is rejected.
  always_comb begin
    one_low = 1'b0;
    low_idx = 2'd0;
    case (rs_reg)
      4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
      default: begin one_low = 1'b0; low_idx = 2'd0; end
    endcase
  end

  // State, column, counters and latched key position.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_reg <= SCAN;
      col_reg   <= 2'd0;
      dwell_reg <= '0;
      cnt_reg   <= '0;
      pat_reg   <= 4'b1111;
      row_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      dwell_reg <= dwell_next;
      cnt_reg   <= cnt_next;
      pat_reg   <= pat_next;
      row_reg   <= row_next;
    end
  end

  // Next-state logic: scan, debounce the press, emit once, wait for release.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    dwell_next = dwell_reg;
    cnt_next   = cnt_reg;
    pat_next   = pat_reg;
    row_next   = row_reg;
    case (state_reg)
      SCAN: begin
        // The first two dwell cycles still show the previous column's rows.
        if (dwell_reg >= SETTLE && one_low) begin
          pat_next   = rs_reg;
          row_next   = low_idx;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end else if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          col_next   = col_reg + 2'd1;
        end else begin
          dwell_next = dwell_reg + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs_reg != pat_reg) begin
          // Bounce: rescan the same column from a fresh dwell.
          dwell_next = '0;
          state_next = SCAN;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = EMIT;
        end else begin
          cnt_next = cnt_reg + DW'(1);
        end
      end
      EMIT: begin
        cnt_next   = '0;
        state_next = RELEASE;
      end
      RELEASE: begin
        // Any low row (held key or a second key) restarts the release count.
        if (rs_reg != 4'b1111) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          dwell_next = '0;
          col_next   = col_reg + 2'd1;
          state_next = SCAN;
        end else begin
          cnt_next = cnt_reg + DW'(1);
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // Registered outputs: strobes are loaded only from the EMIT state.
  always_ff @(posedge Clock) begin
    if (reset) begin
      digit     <= 4'b1111;
      opSel     <= 1'b0;
      validHigh <= 1'b0;
      operand   <= 1'b0;
      negative  <= 1'b0;
      equals    <= 1'b0;
      memRecall <= 1'b0;
      clear     <= 1'b0;
    end else begin
      validHigh <= 1'b0;
      operand   <= 1'b0;
      negative  <= 1'b0;
      equals    <= 1'b0;
      memRecall <= 1'b0;
      clear     <= 1'b0;
      if (state_reg == EMIT) begin
        digit     <= code;
        validHigh <= 1'b1;
        case (code)
          4'd10: negative <= 1'b1;
          4'd11: begin operand <= 1'b1; opSel <= 1'b0; end
          4'd12: begin operand <= 1'b1; opSel <= 1'b1; end
          4'd13: equals <= 1'b1;
          4'd14: memRecall <= 1'b1;
          4'd15: clear <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever an output pulse appears.
module tb_keypad_decoder;

  logic       Clock = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit;
  logic       validHigh, operand, opSel, negative, equals, memRecall, clear;

  logic [15:0] pressed;  // bit r*4+c set = key at row r, column c held

  int n_vec = 0;
  int n_err = 0;

  // Expected event: {validHigh, digit, operand, opSel, negative, equals, memRecall, clear}
  logic [10:0] exp_q[$];

  keypad_decoder #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .Clock(Clock), .reset(reset), .rows(rows), .cols(cols), .digit(digit),
    .validHigh(validHigh), .operand(operand), .opSel(opSel), .negative(negative),
    .equals(equals), .memRecall(memRecall), .clear(clear)
  );

  always #5 Clock = ~Clock;

  // Keypad matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!cols[c] && pressed[r*4+c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] ev(input logic [3:0] d, input logic op, input logic os,
                                     input logic ng, input logic eq, input logic mr,
                                     input logic cl);
    return {1'b1, d, op, os, ng, eq, mr, cl};
  endfunction

  // Monitor: any pulse must match the oldest expected event.
  always @(negedge Clock) begin
    logic [10:0] act;
    act = {validHigh, digit, operand, opSel, negative, equals, memRecall, clear};
    if (validHigh | operand | negative | equals | memRecall | clear) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(act), 32'd0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        $display("event digit=%0d strobes=%06b", digit, act[5:0]);
        check("event", 32'(act), 32'(e));
      end
    end
  end

  task automatic press_key(input int idx, input logic [10:0] e);
    exp_q.push_back(e);
    pressed[idx] = 1'b1;
    repeat (60) @(negedge Clock);
    check("event_seen", 32'(exp_q.size()), 32'd0);
    pressed[idx] = 1'b0;
    repeat (20) @(negedge Clock);
  endtask

  initial begin
    logic [3:0] exp_cols;
    reset   = 1'b1;
    pressed = '0;
    repeat (3) @(negedge Clock);
    reset = 1'b0;
    check("reset_cols", 32'(cols), 32'h e);
    check("reset_digit", 32'(digit), 32'h f);
    check("reset_opsel", 32'(opSel), 32'd0);
    check("reset_pulses", 32'({validHigh, operand, negative, equals, memRecall, clear}), 32'd0);

    // Idle scan: column rotates every 4 cycles.
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clock);
      exp_cols = 4'b0001;
      exp_cols = ~(exp_cols << ((n / 4) % 4));
      check("scan_cols", 32'(cols), 32'(exp_cols));
    end

    // Key 5 held then released; column frozen until release completes.
    exp_q.push_back(ev(4'd5, 0, 0, 0, 0, 0, 0));
    pressed[5] = 1'b1;
    repeat (60) @(negedge Clock);
    check("event_seen", 32'(exp_q.size()), 32'd0);
    check("cols_frozen", 32'(cols), 32'h d);
    pressed[5] = 1'b0;
    repeat (5) @(negedge Clock);
    check("release_hold", 32'(cols), 32'h d);
    repeat (6) @(negedge Clock);
    check("col_advance", 32'(cols), 32'h b);
    check("digit_hold", 32'(digit), 32'd5);
    repeat (10) @(negedge Clock);

    // B then #: operand with opSel=1, then equals with opSel unchanged.
    press_key(7, ev(4'd12, 1, 1, 0, 0, 0, 0));
    check("opsel_b", 32'(opSel), 32'd1);
    press_key(14, ev(4'd13, 0, 1, 0, 1, 0, 0));
    check("opsel_hold", 32'(opSel), 32'd1);

    // Bounce on key 1: no event until the contact is steady.
    for (int i = 0; i < 10; i++) begin
      pressed[0] = (i % 2 == 0);
      repeat (3) @(negedge Clock);
    end
    press_key(0, ev(4'd1, 0, 1, 0, 0, 0, 0));

    // Remaining code map and strobes.
    press_key(12, ev(4'd10, 0, 1, 1, 0, 0, 0));  // *
    press_key(13, ev(4'd0, 0, 1, 0, 0, 0, 0));   // 0
    press_key(11, ev(4'd14, 0, 1, 0, 0, 1, 0));  // C
    press_key(15, ev(4'd15, 0, 1, 0, 0, 0, 1));  // D

    // Second key pressed while the first is held: no extra event.
    exp_q.push_back(ev(4'd9, 0, 1, 0, 0, 0, 0));
    pressed[10] = 1'b1;
    repeat (40) @(negedge Clock);
    pressed[2] = 1'b1;
    repeat (30) @(negedge Clock);
    check("event_seen", 32'(exp_q.size()), 32'd0);
    pressed[2] = 1'b0;
    repeat (30) @(negedge Clock);
    pressed = '0;
    repeat (20) @(negedge Clock);

    // Two rows low in column 0: ignored; releasing one gives key 4.
    pressed[4] = 1'b1;
    pressed[8] = 1'b1;
    repeat (40) @(negedge Clock);
    check("multi_no_event", 32'(digit), 32'd9);
    exp_q.push_back(ev(4'd4, 0, 1, 0, 0, 0, 0));
    pressed[8] = 1'b0;
    repeat (60) @(negedge Clock);
    check("event_seen", 32'(exp_q.size()), 32'd0);
    pressed = '0;
    repeat (10) @(negedge Clock);
    check("post_release_col", 32'(cols), 32'h d);

    // Key 5 pressed now; reset once the debounce count has reached 5.
    pressed[5] = 1'b1;
    repeat (8) @(negedge Clock);
    reset   = 1'b1;
    pressed = '0;
    @(negedge Clock);
    check("abort_cols", 32'(cols), 32'h e);
    check("abort_digit", 32'(digit), 32'h f);
    check("abort_opsel", 32'(opSel), 32'd0);
    check("abort_pulses", 32'({validHigh, operand, negative, equals, memRecall, clear}), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge Clock);

    // B then A toggles the operator select.
    press_key(7, ev(4'd12, 1, 1, 0, 0, 0, 0));
    press_key(3, ev(4'd11, 1, 0, 0, 0, 0, 0));
    check("opsel_a", 32'(opSel), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Upstream front end of the calculator.
- Scans a 4x4 matrix keypad, synchronises and debounces the row lines, and identifies the pressed key.
- Emits exactly one single-cycle event per physical press: digit code plus operand/equals/sign/recall/clear strobes.
- Its outputs drive the calculator control FSM directly (digit, validHigh, operand, negative, equals, memRecall).

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven low while scanning (>=2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (>=1).

Ports:
- Clock  input  1  system clock.
- reset  input  1  synchronous, active-high; clock Clock.
- rows  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
- digit  output  4  code of last accepted key; holds until the next accepted key.
- validHigh  output  1  one-cycle pulse, any key accepted.
- operand  output  1  one-cycle pulse, A or B accepted.
- opSel  output  1  0 = add (A), 1 = subtract (B); updates with the operand pulse, holds otherwise.
- negative  output  1  one-cycle pulse, * (sign) accepted.
- equals  output  1  one-cycle pulse, # accepted.
- memRecall  output  1  one-cycle pulse, C accepted.
- clear  output  1  one-cycle pulse, D accepted.

Behaviour:
- rows pass through a 2-flop synchroniser (rs). All decisions use rs.
- Key map, row r / col c, row 0 top, col 0 = cols[0]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Codes: 0-9 map to digit 0-9; * = 10; A = 11; B = 12; # = 13; C = 14; D = 15.
- Reset values:
  - cols = 4'b1110, state = SCAN, column index 0, counters 0.
  - digit = 4'b1111, opSel = 0, all pulses 0.
  - Reset mid-operation aborts any debounce or release wait with no pulse emitted.
- State SCAN:
  - Drive current column low.
  - Dwell counter counts 0..SCAN_DIV-1, then the column rotates (0→1→2→3→0).
  - Ignore rs for the first 2 cycles of each dwell (synchroniser settle).
  - If rs has exactly one bit low: latch row/col, clear debounce counter, go to DEBOUNCE.
  - If rs has more than one bit low (multi-key): ignore and keep scanning.
- State DEBOUNCE:
  - Column is held.
  - Each cycle rs equals the latched pattern, the counter increments.
  - Any mismatch returns to SCAN with the column held, dwell restarting at 0, and no pulse.
  - When the counter reaches DEBOUNCE_CYCLES, go to EMIT.
- State EMIT (one cycle), registered outputs:
  - On the next edge, digit is loaded with the code and validHigh is 1 for exactly one cycle.
  - The matching strobe (operand/negative/equals/memRecall/clear) is 1 in the same cycle. Digits 0-9 assert validHigh only.
  - opSel updates only on A/B.
  - Then go to RELEASE.
- State RELEASE:
  - Column held. rs = 4'b1111 for DEBOUNCE_CYCLES consecutive cycles returns to SCAN with the column advanced.
  - Any low row restarts the count. Holding a key never repeats.
  - Pressing a second key while the first is held produces no event.
- Latency: last bounce edge, then 2 cycles sync, then DEBOUNCE_CYCLES stable, then 1 cycle; validHigh is registered.
- Strobes are mutually exclusive and never asserted outside the EMIT cycle.
- A key in a column not currently driven is detected when the scan reaches it; no missed press if held for at least 4*SCAN_DIV + DEBOUNCE_CYCLES cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, then idle rows=1111 for 40 cycles → cols cycles 1110,1101,1011,0111 every 4 cycles; digit=1111; no pulses.
- Hold key 5 (row1 low when cols[1] low) for 60 cycles, then release → exactly one validHigh pulse, digit=5, no other strobes; cols frozen at 1101 until 8 release cycles pass.
- Press B → validHigh and operand pulse in the same cycle, digit=12, opSel=1. Then press # → equals pulse, digit=13, opSel stays 1.
- Bounce: toggle row0 low/high every 3 cycles for 30 cycles, then steady low → single pulse only after 8 stable cycles; no pulse during the bounce.
- Two rows low simultaneously in one column → no pulse. Release one row → normal single-key event.
- Assert reset during DEBOUNCE at count 5 → no pulse; outputs at reset values next cycle; cols=1110.
